pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage CPU. It generates the enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the registered forwarding selects for the EX-stage operand muxes. It resolves three hazard types:
- load-use hazards;
- taken-branch redirects;
- variable-latency data-memory accesses, with a timeout error state.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl_hazard_detect.sv | 46 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller slice.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [1:0]  FWD_RF    = 2'b00;
    localparam logic [1:0]  FWD_EXMEM = 2'b01;
    localparam logic [1:0]  FWD_MEMWB = 2'b10;
    localparam logic [31:0] BUBBLE    = 32'h0000_0000;

    // Youngest producer wins: EX/MEM result is newer than MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_EXMEM;
        else if (mem_hit) return FWD_MEMWB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls between datapath and pipe_ctrl.
// master: the controller; slave: the datapath stages.
interface pipe_ctrl_if;
    logic [4:0]  id_rs, id_rt;
    logic        id_uses_rs, id_uses_rt;
    logic [4:0]  ex_rd;
    logic        ex_RegWrite, ex_MemtoReg;
    logic [4:0]  mem_rd;
    logic        mem_RegWrite;
    logic        ex_branch_taken;
    logic        dmem_req, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        err;
    logic [31:0] stall_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_rd, ex_RegWrite, ex_MemtoReg, mem_rd, mem_RegWrite,
        input  ex_branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en,
        output ifid_flush, idex_flush, memwb_flush,
        output fwd_a, fwd_b, err, stall_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_rd, ex_RegWrite, ex_MemtoReg, mem_rd, mem_RegWrite,
        output ex_branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  ifid_flush, idex_flush, memwb_flush,
        input  fwd_a, fwd_b, err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational RAW matcher: produces the stall request and the forwarding
// selects for the instruction in ID against the EX and MEM producers.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_RegWrite,
    input  logic       ex_MemtoReg,
    input  logic [4:0] mem_rd,
    input  logic       mem_RegWrite,
    output logic       stall,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b
);
    logic ex_live, mem_live;
    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic ex_read, mem_read;

    always_comb begin
        ex_live  = ex_RegWrite && (ex_rd != '0);
        mem_live = mem_RegWrite && (mem_rd != '0);
        ex_rs    = ex_live && (id_rs == ex_rd);
        ex_rt    = ex_live && (id_rt == ex_rd);
        mem_rs   = mem_live && (id_rs == mem_rd);
        mem_rt   = mem_live && (id_rt == mem_rd);
        ex_read  = (id_uses_rs && ex_rs) || (id_uses_rt && ex_rt);
        mem_read = (id_uses_rs && mem_rs) || (id_uses_rt && mem_rt);

        // Without forwarding every live RAW must wait until its producer is in WB.
        if (FWD_EN) begin
            stall = ex_MemtoReg && ex_read;
            sel_a = fwd_sel(ex_rs, mem_rs);
            sel_b = fwd_sel(ex_rt, mem_rt);
        end else begin
            stall = ex_read || mem_read;
            sel_a = FWD_RF;
            sel_b = FWD_RF;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: enables, flushes, memory-wait FSM, forwarding.
// Define PIPE_CTRL_FORWARD_EN for EX-operand forwarding; otherwise RAW hazards stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int unsigned      CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_hold, hz_stall;
    logic [1:0]       sel_a, sel_b;
    logic             pc_en, ifid_en, idex_en, exmem_en;
    logic             ifid_flush, idex_flush, memwb_flush;
    logic             err_q;
    logic [31:0]      stall_q;

    pipe_ctrl_hazard_detect #(.FWD_EN(FWD_EN)) u_hazard (
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rs   (bus.id_uses_rs),
        .id_uses_rt   (bus.id_uses_rt),
        .ex_rd        (bus.ex_rd),
        .ex_RegWrite  (bus.ex_RegWrite),
        .ex_MemtoReg  (bus.ex_MemtoReg),
        .mem_rd       (bus.mem_rd),
        .mem_RegWrite (bus.mem_RegWrite),
        .stall        (hz_stall),
        .sel_a        (sel_a),
        .sel_b        (sel_b)
    );

    // The completing cycle is not frozen, so an N-cycle access costs N-1 stalls.
    always_comb begin
        state_nx = state;
        mem_hold = 1'b0;
        unique case (state)
            RUN: begin
                mem_hold = bus.dmem_req && !bus.dmem_ready;
                if (mem_hold) state_nx = MWAIT;
            end
            MWAIT: begin
                mem_hold = !bus.dmem_ready;
                if (bus.dmem_ready)             state_nx = RUN;
                else if (wait_cnt == TIMEOUT_V) state_nx = ERR;
            end
            ERR:     mem_hold = 1'b1;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            // hold the RUN/no-hazard defaults while in reset
        end else if (mem_hold) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hz_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            state <= state_nx;
            if (state != MWAIT)         wait_cnt <= '0;
            else if (state_nx == MWAIT) wait_cnt <= wait_cnt + 1'b1;
            if (state_nx == ERR)        err_q <= 1'b1;
            if (!pc_en && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

`ifdef PIPE_CTRL_FORWARD_EN
    logic [1:0] fwd_a_q, fwd_b_q;

    always_ff @(posedge clk) begin
        if (rst || idex_flush) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (idex_en) begin
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
        end
    end

    assign bus.fwd_a = fwd_a_q;
    assign bus.fwd_b = fwd_b_q;
`else
    assign bus.fwd_a = sel_a;
    assign bus.fwd_b = sel_b;
`endif

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.err         = err_q;
    assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random traffic
// against a behavioural model of the control rules.
module tb_pipe_ctrl;
    localparam int unsigned TO = 4;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    // model state
    bit          m_wait, m_err;
    int unsigned m_wcyc;
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cnt;
    bit e_pc, e_ifid, e_idex, e_exmem, e_fl_ifid, e_fl_idex, e_fl_memwb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((bus.id_uses_rs && bus.id_rs == r) ||
                               (bus.id_uses_rt && bus.id_rt == r));
    endfunction

    function automatic logic [1:0] pick(input logic [4:0] src);
        if (!FWD) return 2'b00;
        if (bus.ex_RegWrite && bus.ex_rd != 5'd0 && bus.ex_rd == src) return 2'b01;
        if (bus.mem_RegWrite && bus.mem_rd != 5'd0 && bus.mem_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit frozen, hz;
        frozen = m_err || (m_wait ? !bus.dmem_ready : (bus.dmem_req && !bus.dmem_ready));
        if (FWD) hz = bus.ex_MemtoReg && bus.ex_RegWrite && reads(bus.ex_rd);
        else     hz = (bus.ex_RegWrite && reads(bus.ex_rd)) || (bus.mem_RegWrite && reads(bus.mem_rd));
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_fl_ifid, e_fl_idex, e_fl_memwb} = 3'b000;
        if (rst) begin
        end else if (frozen) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            e_fl_memwb = 1'b1;
        end else if (bus.ex_branch_taken) begin
            e_fl_ifid = 1'b1;
            e_fl_idex = 1'b1;
        end else if (hz) begin
            e_pc = 1'b0;
            e_ifid = 1'b0;
            e_fl_idex = 1'b1;
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            m_wait = 0; m_err = 0; m_wcyc = 0; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 32'd0;
        end else begin
            if (!e_pc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (e_fl_idex) begin
                m_fa = 2'b00; m_fb = 2'b00;
            end else if (e_idex) begin
                m_fa = pick(bus.id_rs); m_fb = pick(bus.id_rt);
            end
            if (m_err) begin
            end else if (m_wait) begin
                if (bus.dmem_ready)  m_wait = 0;
                else if (m_wcyc == TO) m_err = 1;
                else                 m_wcyc++;
            end else if (bus.dmem_req && !bus.dmem_ready) begin
                m_wait = 1; m_wcyc = 0;
            end
        end
    endtask

    task automatic eval();
        #2;
        model_comb();
        chk("pc_en", bus.pc_en, e_pc);
        chk("ifid_en", bus.ifid_en, e_ifid);
        chk("idex_en", bus.idex_en, e_idex);
        chk("exmem_en", bus.exmem_en, e_exmem);
        chk("ifid_flush", bus.ifid_flush, e_fl_ifid);
        chk("idex_flush", bus.idex_flush, e_fl_idex);
        chk("memwb_flush", bus.memwb_flush, e_fl_memwb);
        chk("fwd_a", bus.fwd_a, m_fa);
        chk("fwd_b", bus.fwd_b, m_fb);
        chk("err", bus.err, m_err);
        chk("stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_rd = 5'd0; bus.ex_RegWrite = 0; bus.ex_MemtoReg = 0;
        bus.mem_rd = 5'd0; bus.mem_RegWrite = 0;
        bus.ex_branch_taken = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
    endtask

    task automatic load_use_setup();
        idle();
        bus.ex_rd = 5'd2; bus.ex_RegWrite = 1; bus.ex_MemtoReg = 1;
        bus.id_rs = 5'd2; bus.id_uses_rs = 1; bus.id_rt = 5'd4; bus.id_uses_rt = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int frz;
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        // reset: a pending memory stall must not show through
        bus.dmem_req = 1;
        eval();
        chk("rst_pc_en", bus.pc_en, 1);
        chk("rst_memwb_flush", bus.memwb_flush, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_fwd_a", bus.fwd_a, 0);
        tick();
        rst = 1'b0;

        // load-use: lw $2 in EX, add $3,$2,$4 in ID
        load_use_setup();
        eval();
        chk("lu_pc_en", bus.pc_en, 0);
        chk("lu_ifid_en", bus.ifid_en, 0);
        chk("lu_idex_flush", bus.idex_flush, 1);
        tick();
        idle();
        bus.mem_rd = 5'd2; bus.mem_RegWrite = 1;
        bus.id_rs = 5'd2; bus.id_uses_rs = 1; bus.id_rt = 5'd4; bus.id_uses_rt = 1;
        eval();
        chk("lu2_pc_en", bus.pc_en, FWD ? 1 : 0);
        tick();
        chk("lu_fwd_a", bus.fwd_a, FWD ? 2 : 0);
        chk("lu_fwd_b", bus.fwd_b, 0);
        idle(); eval(); tick();
        chk("lu_stall_cnt", bus.stall_cnt, FWD ? 1 : 2);

        // back-to-back ALU: add $5 in EX, sub reading $5 in ID
        idle();
        bus.ex_rd = 5'd5; bus.ex_RegWrite = 1;
        bus.id_rs = 5'd5; bus.id_uses_rs = 1; bus.id_rt = 5'd6; bus.id_uses_rt = 1;
        eval();
        chk("alu_pc_en", bus.pc_en, FWD ? 1 : 0);
        tick();
        chk("alu_fwd_a", bus.fwd_a, FWD ? 1 : 0);
        idle();
        bus.mem_rd = 5'd5; bus.mem_RegWrite = 1;
        bus.id_rs = 5'd5; bus.id_uses_rs = 1;
        eval();
        chk("alu2_pc_en", bus.pc_en, FWD ? 1 : 0);
        tick();
        idle(); eval(); tick();
        chk("alu_stall_cnt", bus.stall_cnt, FWD ? 1 : 4);

        // taken branch overrides a simultaneous load-use
        load_use_setup();
        bus.ex_branch_taken = 1;
        eval();
        chk("br_ifid_flush", bus.ifid_flush, 1);
        chk("br_idex_flush", bus.idex_flush, 1);
        chk("br_pc_en", bus.pc_en, 1);
        chk("br_ifid_en", bus.ifid_en, 1);
        tick();
        chk("br_fwd_a", bus.fwd_a, 0);
        idle(); eval(); tick();

        // memory wait: ready three cycles after the request
        idle();
        bus.dmem_req = 1;
        frz = 0;
        for (int k = 0; k < 4; k++) begin
            bus.dmem_ready = (k == 3);
            eval();
            if (bus.memwb_flush) frz++;
            if (k == 3) chk("mw_done_pc_en", bus.pc_en, 1);
            tick();
        end
        chk("mw_frozen_cycles", frz, 3);
        idle(); eval(); tick();
        chk("mw_stall_cnt", bus.stall_cnt, FWD ? 4 : 7);

        // $zero producer never stalls or forwards
        idle();
        bus.ex_rd = 5'd0; bus.ex_RegWrite = 1; bus.ex_MemtoReg = 1;
        bus.id_rs = 5'd0; bus.id_uses_rs = 1; bus.id_rt = 5'd0; bus.id_uses_rt = 1;
        eval();
        chk("zero_pc_en", bus.pc_en, 1);
        tick();
        chk("zero_fwd_a", bus.fwd_a, 0);

        // ready on the very cycle the wait counter hits the limit: back to RUN
        idle();
        bus.dmem_req = 1;
        for (int k = 0; k < 6; k++) begin
            bus.dmem_ready = (k == 5);
            eval();
            tick();
        end
        chk("edge_err", bus.err, 0);
        idle(); eval();
        chk("edge_pc_en", bus.pc_en, 1);
        tick();
        chk("edge_stall_cnt", bus.stall_cnt, FWD ? 9 : 12);

        // random traffic; ready is forced before the timeout can trigger
        for (int n = 0; n < 400; n++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rs = 1'($urandom_range(0, 1));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.ex_RegWrite = 1'($urandom_range(0, 1));
            bus.ex_MemtoReg = 1'($urandom_range(0, 1));
            bus.mem_rd = 5'($urandom_range(0, 3));
            bus.mem_RegWrite = 1'($urandom_range(0, 1));
            bus.ex_branch_taken = ($urandom_range(0, 9) < 2);
            bus.dmem_req = ($urandom_range(0, 9) < 2);
            bus.dmem_ready = (m_wait && m_wcyc >= 2) ? 1'b1 : ($urandom_range(0, 9) < 6);
            eval();
            tick();
        end

        // timeout with MEM_TIMEOUT=4: ERR after the sixth edge, then sticky
        idle(); eval(); tick();
        bus.dmem_req = 1;
        for (int k = 0; k < 6; k++) begin
            eval();
            tick();
            if (k == 4) chk("to_err_early", bus.err, 0);
        end
        chk("to_err", bus.err, 1);
        bus.dmem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("to_pc_en", bus.pc_en, 0);
            chk("to_memwb_flush", bus.memwb_flush, 1);
            tick();
            chk("to_err_sticky", bus.err, 1);
        end
        rst = 1'b1;
        eval();
        chk("to_rst_pc_en", bus.pc_en, 1);
        tick();
        rst = 1'b0;
        idle();
        chk("to_rst_err", bus.err, 0);
        chk("to_rst_stall_cnt", bus.stall_cnt, 0);
        eval();
        chk("to_rst_run", bus.pc_en, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
